// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one framebuffer write port between CPU pixel writes
// and a rectangle-fill engine. The fill engine walks the rectangle in raster
// order. A starvation counter makes sure a busy CPU cannot lock the fill out.
module vga_fb_arbiter #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int STARVE_MAX = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_cpuValid,
    input  logic [31:0] i_cpuAddr,
    input  logic [31:0] i_cpuData,
    output logic        o_cpuReady,
    input  logic        i_fillStart,
    input  logic [7:0]  i_fillX0,
    input  logic [7:0]  i_fillY0,
    input  logic [7:0]  i_fillX1,
    input  logic [7:0]  i_fillY1,
    input  logic [11:0] i_fillColor,
    output logic        o_fillBusy,
    output logic        o_fillDone,
    output logic [31:0] o_pxlAddr,
    output logic [31:0] o_pxlData,
    output logic        o_pxlWe
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t state, next_state;

    logic [7:0]    x0_q, x1_q, y1_q;
    logic [11:0]   color_q;
    logic [7:0]    cur_x, cur_y;
    logic [SW-1:0] starve_q;

    logic [7:0]  start_x0, start_y0, start_x1, start_y1;
    logic        start_empty;
    logic        accept_start;
    logic        cpu_grant, fill_grant;
    logic        last_pixel;
    logic [31:0] fill_addr;

    // Corners are clamped into the framebuffer before anything else uses them
    function automatic logic [7:0] clampX(input logic [7:0] v);
        if (int'(v) > WIDTH - 1) return 8'(WIDTH - 1);
        return v;
    endfunction

    function automatic logic [7:0] clampY(input logic [7:0] v);
        if (int'(v) > HEIGHT - 1) return 8'(HEIGHT - 1);
        return v;
    endfunction

    assign start_x0     = clampX(i_fillX0);
    assign start_x1     = clampX(i_fillX1);
    assign start_y0     = clampY(i_fillY0);
    assign start_y1     = clampY(i_fillY1);
    assign start_empty  = (start_x0 > start_x1) || (start_y0 > start_y1);
    assign accept_start = (state == IDLE) && i_fillStart;

    assign last_pixel = (cur_x == x1_q) && (cur_y == y1_q);
    assign fill_addr  = ({24'b0, cur_y} * 32'(WIDTH)) + {24'b0, cur_x};

    // State register; reset abandons any fill in progress
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= next_state;
    end

    // Next state and arbitration: CPU wins in IDLE, and in FILL only until the
    // starvation limit is reached, after which the fill takes one slot
    always_comb begin
        next_state = state;
        cpu_grant  = 1'b0;
        fill_grant = 1'b0;
        if (i_reset_n) begin
            case (state)
                IDLE: begin
                    cpu_grant = i_cpuValid;
                    if (i_fillStart && !start_empty) next_state = FILL;
                end
                FILL: begin
                    if (i_cpuValid && (starve_q < SW'(STARVE_MAX))) cpu_grant = 1'b1;
                    else                                             fill_grant = 1'b1;
                    if (fill_grant && last_pixel) next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    assign o_cpuReady = cpu_grant;
    assign o_fillBusy = (state == FILL);

    // Registered write port, fill parameters, raster cursor and starvation count
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_pxlWe    <= 1'b0;
            o_pxlAddr  <= 32'd0;
            o_pxlData  <= 32'd0;
            o_fillDone <= 1'b0;
            x0_q       <= 8'd0;
            x1_q       <= 8'd0;
            y1_q       <= 8'd0;
            color_q    <= 12'd0;
            cur_x      <= 8'd0;
            cur_y      <= 8'd0;
            starve_q   <= '0;
        end else begin
            o_pxlWe    <= cpu_grant || fill_grant;
            o_fillDone <= (fill_grant && last_pixel) || (accept_start && start_empty);
            if (cpu_grant) begin
                o_pxlAddr <= i_cpuAddr;
                o_pxlData <= i_cpuData;
            end else if (fill_grant) begin
                o_pxlAddr <= fill_addr;
                o_pxlData <= {20'b0, color_q};
            end

            if (state == FILL) begin
                if (cpu_grant)       starve_q <= starve_q + 1'b1;
                else if (fill_grant) starve_q <= '0;
            end else begin
                starve_q <= '0;
            end

            if (accept_start && !start_empty) begin
                x0_q    <= start_x0;
                x1_q    <= start_x1;
                y1_q    <= start_y1;
                color_q <= i_fillColor;
                cur_x   <= start_x0;
                cur_y   <= start_y0;
            end else if (fill_grant) begin
                if (cur_x == x1_q) begin
                    cur_x <= x0_q;
                    cur_y <= cur_y + 8'd1;
                end else begin
                    cur_x <= cur_x + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: drives directed and random traffic into vga_fb_arbiter and
// compares every cycle against a queue-based model of the expected write stream.
module tb_vga_fb_arbiter;

    localparam int WIDTH      = 160;
    localparam int HEIGHT     = 120;
    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        resetN;
    logic        cpuValid;
    logic [31:0] cpuAddr, cpuData;
    logic        cpuReady;
    logic        fillStart;
    logic [7:0]  fillX0, fillY0, fillX1, fillY1;
    logic [11:0] fillColor;
    logic        fillBusy, fillDone;
    logic [31:0] pxlAddr, pxlData;
    logic        pxlWe;

    int checkCount = 0;
    int failCount  = 0;

    // Model state: pending fill pixels as a plain address list
    int unsigned mQueue[$];
    bit          mBusy;
    int          mStarve;
    logic [11:0] mColor;
    logic        eWe, eDone;
    logic [31:0] eAddr, eData;

    vga_fb_arbiter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .STARVE_MAX(STARVE_MAX)) dut (
        .i_clk(clk), .i_reset_n(resetN),
        .i_cpuValid(cpuValid), .i_cpuAddr(cpuAddr), .i_cpuData(cpuData),
        .o_cpuReady(cpuReady),
        .i_fillStart(fillStart),
        .i_fillX0(fillX0), .i_fillY0(fillY0), .i_fillX1(fillX1), .i_fillY1(fillY1),
        .i_fillColor(fillColor),
        .o_fillBusy(fillBusy), .o_fillDone(fillDone),
        .o_pxlAddr(pxlAddr), .o_pxlData(pxlData), .o_pxlWe(pxlWe)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Model reaction to one rising edge, using the inputs as they stand
    task automatic modelEdge();
        bit cg, fg, busyNext;
        int cx0, cy0, cx1, cy1;
        if (!resetN) begin
            mBusy = 0; mQueue.delete(); mStarve = 0;
            eWe = 0; eAddr = 0; eData = 0; eDone = 0;
            return;
        end
        cg = cpuValid && (!mBusy || mStarve < STARVE_MAX);
        fg = mBusy && !cg;
        busyNext = mBusy;
        eWe = cg || fg;
        eDone = 0;
        if (cg) begin
            eAddr = cpuAddr;
            eData = cpuData;
        end
        if (fg) begin
            eAddr = mQueue.pop_front();
            eData = {20'b0, mColor};
            if (mQueue.size() == 0) begin
                eDone = 1;
                busyNext = 0;
            end
        end
        if (mBusy) mStarve = cg ? mStarve + 1 : 0;
        else       mStarve = 0;
        if (!mBusy && fillStart) begin
            cx0 = (int'(fillX0) > WIDTH - 1)  ? WIDTH - 1  : int'(fillX0);
            cx1 = (int'(fillX1) > WIDTH - 1)  ? WIDTH - 1  : int'(fillX1);
            cy0 = (int'(fillY0) > HEIGHT - 1) ? HEIGHT - 1 : int'(fillY0);
            cy1 = (int'(fillY1) > HEIGHT - 1) ? HEIGHT - 1 : int'(fillY1);
            if (cx0 > cx1 || cy0 > cy1) begin
                eDone = 1;
            end else begin
                for (int y = cy0; y <= cy1; y++)
                    for (int x = cx0; x <= cx1; x++)
                        mQueue.push_back(y * WIDTH + x);
                mColor = fillColor;
                busyNext = 1;
            end
        end
        mBusy = busyNext;
    endtask

    // One clock cycle with the current inputs: check combinational outputs
    // mid-cycle, then the registered outputs just after the edge
    task automatic applyStimulus();
        @(negedge clk);
        #1;
        checkOutput("cpuReady", 32'(cpuReady), 32'(resetN && cpuValid && (!mBusy || mStarve < STARVE_MAX)));
        checkOutput("fillBusy", 32'(fillBusy), 32'(mBusy));
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("pxlWe", 32'(pxlWe), 32'(eWe));
        checkOutput("fillDone", 32'(fillDone), 32'(eDone));
        checkOutput("pxlAddr", pxlAddr, eAddr);
        checkOutput("pxlData", pxlData, eData);
    endtask

    task automatic applyFill(input int x0, input int y0, input int x1, input int y1, input logic [11:0] color);
        fillX0 = 8'(x0); fillY0 = 8'(y0); fillX1 = 8'(x1); fillY1 = 8'(y1);
        fillColor = color;
        fillStart = 1'b1;
        applyStimulus();
        fillStart = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        cpuValid = 1'b0;
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    // Test sequence: reset, directed fills, starvation, clamping, reset abort, random
    initial begin
        int doneAt, writes;
        resetN = 1'b0; cpuValid = 1'b1; cpuAddr = 32'h1234; cpuData = 32'h5678;
        fillStart = 1'b0; fillX0 = 0; fillY0 = 0; fillX1 = 0; fillY1 = 0; fillColor = 0;
        mBusy = 0; mStarve = 0; mColor = 0; eWe = 0; eDone = 0; eAddr = 0; eData = 0;

        applyStimulus();
        applyStimulus();
        resetN = 1'b1;
        cpuValid = 1'b0;
        idleCycles(2);

        // CPU writes pass straight through while idle
        cpuValid = 1'b1; cpuAddr = 32'hDEAD_0001; cpuData = 32'hCAFE_0001;
        applyStimulus();
        cpuValid = 1'b0;
        idleCycles(1);

        // Single-row fill and 2x2 fill
        applyFill(2, 3, 4, 3, 12'hABC);
        idleCycles(5);
        applyFill(0, 0, 1, 1, 12'h123);
        idleCycles(6);

        // Ten-pixel fill under a constantly busy CPU
        cpuValid = 1'b1;
        cpuAddr = $urandom; cpuData = $urandom;
        applyFill(0, 0, 9, 0, 12'h5A5);
        doneAt = 0;
        for (int i = 1; i <= 60; i++) begin
            cpuAddr = $urandom; cpuData = $urandom;
            applyStimulus();
            if (fillDone === 1'b1 && doneAt == 0) doneAt = i;
            if (doneAt != 0) break;
        end
        checkOutput("starveLatency", 32'(doneAt), 32'd50);
        idleCycles(2);

        // Empty rectangle, then clamped corners
        applyFill(5, 0, 2, 0, 12'hFFF);
        idleCycles(3);
        applyFill(150, 115, 200, 130, 12'h0F0);
        idleCycles(55);

        // A second start during a fill must be ignored
        applyFill(10, 10, 13, 10, 12'h111);
        applyFill(0, 0, 0, 0, 12'h222);
        idleCycles(6);

        // Reset on the third fill write aborts the fill
        applyFill(0, 5, 7, 5, 12'h333);
        writes = 0;
        for (int i = 0; i < 10 && writes < 3; i++) begin
            applyStimulus();
            if (pxlWe === 1'b1) writes++;
        end
        checkOutput("abortWrites", 32'(writes), 32'd3);
        resetN = 1'b0;
        applyStimulus();
        resetN = 1'b1;
        idleCycles(2);
        applyFill(3, 1, 5, 2, 12'h444);
        idleCycles(8);

        // Random traffic with occasional fills and resets
        for (int i = 0; i < 600; i++) begin
            resetN   = ($urandom_range(0, 99) >= 2);
            cpuValid = $urandom_range(0, 1);
            cpuAddr  = $urandom;
            cpuData  = $urandom;
            fillStart = ($urandom_range(0, 9) == 0);
            fillX0 = 8'($urandom_range(0, 170));
            fillX1 = fillX0 + 8'($urandom_range(0, 5));
            fillY0 = 8'($urandom_range(0, 125));
            fillY1 = fillY0 + 8'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                fillX1 = fillX0;
                fillX0 = fillX0 + 8'd1;
            end
            fillColor = 12'($urandom);
            applyStimulus();
        end
        resetN = 1'b1; fillStart = 1'b0;
        idleCycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
